// File: rtl/dsp_packetizer.sv
// Framer: FIFO-buffered 12-bit ADC samples out as fixed-length {sof, ovf, sample} packets.
// Optional DSP_PACKETIZER_OVR_ABORT_EN: an over-range word closes its packet early.
module dsp_packetizer #(
  parameter int PKT_LEN    = 33,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [11:0] i_sample,
  input  logic        i_sample_valid,
  input  logic        i_sample_ovr,
  input  logic        i_enable,
  output logic [13:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [12:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW:0]   fill;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic [12:0]   rd_data;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    gap_reg;

  logic          xfer;
  logic          abort_hit;
  logic          pkt_done;
  logic          start;
  logic          next_load;

  // Fullness is taken before this cycle's read, so a full FIFO drops even while draining.
  assign fill    = wr_ptr_reg - rd_ptr_reg;
  assign full    = (fill == FULL_CNT);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign wr_en   = i_sample_valid && !full;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= {i_sample_ovr, i_sample};
    end
  end

`ifdef DSP_PACKETIZER_OVR_ABORT_EN
  assign abort_hit = o_data[12];
`else
  assign abort_hit = 1'b0;
`endif

  assign xfer      = o_valid && i_ready;
  assign pkt_done  = (state_reg == SEND) && xfer && ((cnt_reg == LAST_CNT) || abort_hit);
  assign start     = (state_reg == IDLE) && i_enable && !empty;
  assign next_load = (state_reg == SEND) && (!o_valid || i_ready) && !pkt_done &&
                     (cnt_reg != LAST_CNT) && !empty;
  assign rd_en     = start || next_load;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      gap_reg    <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_drop <= i_sample_valid && full;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (start) begin
            o_data    <= {1'b1, rd_data};
            o_valid   <= 1'b1;
            cnt_reg   <= CW'(1);
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (pkt_done) begin
            o_valid   <= 1'b0;
            gap_reg   <= '0;
            state_reg <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (next_load) begin
            o_data  <= {1'b0, rd_data};
            o_valid <= 1'b1;
            cnt_reg <= cnt_reg + 1'b1;
          end else if (xfer) begin
            // Underrun: packet stays open until the FIFO refills.
            o_valid <= 1'b0;
          end
        end
        GAP: begin
          if (gap_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
